// File: rtl/usb_rx_pkt_ctrl_if.sv
// Handshake/bus bundle between the USB RX front end, the packet controller and the FIFO/CRC side.
// slave = controller view, master = front-end/testbench view.
interface usb_rx_pkt_ctrl_if #(
   parameter int CNT_W = 7
);
   logic             d_edge;
   logic             byte_received;
   logic [7:0]       rx_byte;
   logic             eop;
   logic             crc5_ok;
   logic             crc16_ok;
   logic             receiving;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic [3:0]       pid;
   logic             pid_valid;
   logic             crc_sel;
   logic             crc_clear;
   logic [CNT_W-1:0] byte_count;
   logic             pkt_done;
   logic             rcv_error;
   logic [2:0]       err_code;

   modport slave (
      input  d_edge, byte_received, rx_byte, eop, crc5_ok, crc16_ok,
      output receiving, wr_en, wr_data, pid, pid_valid, crc_sel, crc_clear,
             byte_count, pkt_done, rcv_error, err_code
   );

   modport master (
      output d_edge, byte_received, rx_byte, eop, crc5_ok, crc16_ok,
      input  receiving, wr_en, wr_data, pid, pid_valid, crc_sel, crc_clear,
             byte_count, pkt_done, rcv_error, err_code
   );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: SYNC/PID checking, CRC selection, byte counting, coded errors.
// Optional inactivity timeout enabled by defining RX_TIMEOUT_EN.
module usb_rx_pkt_ctrl #(
   parameter int         MAX_BYTES   = 66,
   parameter logic [7:0] SYNC_BYTE   = 8'h80,
   parameter int         CNT_W       = 7,
   parameter int         TIMEOUT_CYC = 96
) (
   input logic               clk,
   input logic               rst,
   usb_rx_pkt_ctrl_if.slave  bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_SYNC_WAIT, S_SYNC_CHK, S_PID_WAIT, S_PID_CHK,
      S_DATA_WAIT, S_DATA_WR, S_CRC_CHK, S_ERROR
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] TWO_CNT = CNT_W'(2);

   state_t           r_state, w_next;
   logic [2:0]       w_err;
   logic [7:0]       r_byte;
   logic             r_eop_cap;
   logic             r_wr_en, r_pid_valid, r_crc_sel, r_crc_clear, r_pkt_done, r_rcv_error;
   logic [7:0]       r_wr_data;
   logic [3:0]       r_pid;
   logic [CNT_W-1:0] r_byte_count;
   logic [2:0]       r_err_code;
   logic             w_wait_st, w_full, w_pid_ok, w_tmo;

   assign w_wait_st = (r_state == S_SYNC_WAIT) || (r_state == S_PID_WAIT) ||
                      (r_state == S_DATA_WAIT);
   assign w_full    = (r_byte_count == MAX_CNT);
   assign w_pid_ok  = (r_byte[7:4] == ~r_byte[3:0]);

`ifdef RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo;
   logic             w_tmo_run;

   assign w_tmo_run = w_wait_st || (r_state == S_ERROR);
   assign w_tmo     = w_tmo_run && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

   // Counter restarts on any state change and on every received byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_tmo <= '0;
      else if (!w_tmo_run || (w_next != r_state) || bus.byte_received)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + TMO_W'(1);
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      w_err  = 3'd0;
      case (r_state)
         S_IDLE:      if (bus.d_edge) w_next = S_SYNC_WAIT;
         S_SYNC_WAIT: begin
            if (bus.byte_received) w_next = S_SYNC_CHK;
            else if (bus.eop)      begin w_next = S_ERROR; w_err = 3'd3; end
            else if (w_tmo)        begin w_next = S_ERROR; w_err = 3'd6; end
         end
         S_SYNC_CHK:  begin
            if (r_byte == SYNC_BYTE) w_next = S_PID_WAIT;
            else                     begin w_next = S_ERROR; w_err = 3'd1; end
         end
         S_PID_WAIT:  begin
            if (bus.byte_received) w_next = S_PID_CHK;
            else if (bus.eop)      begin w_next = S_ERROR; w_err = 3'd3; end
            else if (w_tmo)        begin w_next = S_ERROR; w_err = 3'd6; end
         end
         S_PID_CHK:   begin
            if (w_pid_ok) w_next = S_DATA_WAIT;
            else          begin w_next = S_ERROR; w_err = 3'd2; end
         end
         S_DATA_WAIT: begin
            if (bus.byte_received) w_next = S_DATA_WR;
            else if (bus.eop)      w_next = S_CRC_CHK;
            else if (w_tmo)        begin w_next = S_ERROR; w_err = 3'd6; end
         end
         S_DATA_WR:   begin
            if (w_full)                      begin w_next = S_ERROR; w_err = 3'd4; end
            else if (bus.eop || r_eop_cap)   w_next = S_CRC_CHK;
            else                             w_next = S_DATA_WAIT;
         end
         S_CRC_CHK:   begin
            case (r_pid[1:0])
               2'b01: begin
                  if (r_byte_count != TWO_CNT) w_err = 3'd7;
                  else if (!bus.crc5_ok)       w_err = 3'd5;
               end
               2'b11: begin
                  if (r_byte_count < TWO_CNT)  w_err = 3'd7;
                  else if (!bus.crc16_ok)      w_err = 3'd5;
               end
               default: if (r_byte_count != '0) w_err = 3'd7;
            endcase
            w_next = (w_err == 3'd0) ? S_IDLE : S_ERROR;
         end
         S_ERROR:     if (bus.eop || r_eop_cap || w_tmo) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // eop seen while waiting is remembered so a 1-cycle eop still closes the packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_byte       <= '0;
         r_eop_cap    <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_data    <= '0;
         r_pid        <= '0;
         r_pid_valid  <= 1'b0;
         r_crc_sel    <= 1'b0;
         r_crc_clear  <= 1'b0;
         r_byte_count <= '0;
         r_pkt_done   <= 1'b0;
         r_rcv_error  <= 1'b0;
         r_err_code   <= '0;
      end else begin
         r_state     <= w_next;
         r_wr_en     <= 1'b0;
         r_pid_valid <= 1'b0;
         r_crc_clear <= 1'b0;
         r_pkt_done  <= 1'b0;
         if (w_wait_st && bus.byte_received) r_byte <= bus.rx_byte;
         if (r_state == S_IDLE)              r_eop_cap <= 1'b0;
         else if (w_wait_st && bus.eop)      r_eop_cap <= 1'b1;
         case (r_state)
            S_IDLE: if (bus.d_edge) begin
               r_rcv_error  <= 1'b0;
               r_err_code   <= '0;
               r_byte_count <= '0;
               r_pid        <= '0;
               r_crc_sel    <= 1'b0;
            end
            S_PID_CHK: if (w_pid_ok) begin
               r_pid       <= r_byte[3:0];
               r_crc_sel   <= (r_byte[1:0] == 2'b11);
               r_pid_valid <= 1'b1;
               r_crc_clear <= 1'b1;
            end
            S_DATA_WR: if (!w_full) begin
               r_wr_en      <= 1'b1;
               r_wr_data    <= r_byte;
               r_byte_count <= r_byte_count + CNT_W'(1);
            end
            S_CRC_CHK: if (w_next == S_IDLE) r_pkt_done <= 1'b1;
            default: ;
         endcase
         if ((r_state != S_ERROR) && (w_next == S_ERROR)) begin
            r_rcv_error <= 1'b1;
            r_err_code  <= w_err;
         end
      end
   end

   assign bus.receiving  = (r_state != S_IDLE);
   assign bus.wr_en      = r_wr_en;
   assign bus.wr_data    = r_wr_data;
   assign bus.pid        = r_pid;
   assign bus.pid_valid  = r_pid_valid;
   assign bus.crc_sel    = r_crc_sel;
   assign bus.crc_clear  = r_crc_clear;
   assign bus.byte_count = r_byte_count;
   assign bus.pkt_done   = r_pkt_done;
   assign bus.rcv_error  = r_rcv_error;
   assign bus.err_code   = r_err_code;
endmodule
